// File: rtl/riscv_pkg.sv
// Shared definitions for the in-order RISC-V pipeline: load/store width codes,
// the bubble instruction word and the memory-stage FSM encoding.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed lane out of a 32-bit read word and sign/zero-extends it
// according to the load width; unknown widths fall back to a full word.
module mem_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] value_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        value_o = rdata_i;
        case (funct3_i)
            F3_B:    value_o = {{24{shifted[7]}},  shifted[7:0]};
            F3_H:    value_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   value_o = {24'h0, shifted[7:0]};
            F3_HU:   value_o = {16'h0, shifted[15:0]};
            default: value_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: registers ALU results through to write_back and runs a
// req/ack data-memory access for loads and stores, stalling upstream meanwhile.
module mem_access
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_instr,
    input  logic [31:0] ex_pc,
    input  logic [4:0]  ex_dstreg_num,
    input  logic [5:0]  ex_alucode,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_value,
    input  logic        ex_reg_we,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] mem_instr,
    output logic [31:0] mem_pc,
    output logic [4:0]  mem_dstreg_num,
    output logic [5:0]  mem_alucode,
    output logic [31:0] mem_alu_result,
    output logic        mem_reg_we,
    output logic        mem_is_load,
    output logic [31:0] mem_load_value,
    output logic        mem_misaligned
);

    state_e      state_q, state_d;
    logic        dreq_q, dreq_d, dwe_q, dwe_d;
    logic [31:0] daddr_q, daddr_d, dwdata_q, dwdata_d;
    logic [3:0]  dbe_q, dbe_d;

    logic [31:0] cap_instr_q, cap_instr_d, cap_pc_q, cap_pc_d, cap_alu_q, cap_alu_d;
    logic [4:0]  cap_rd_q, cap_rd_d;
    logic [5:0]  cap_alucode_q, cap_alucode_d;
    logic        cap_reg_we_q, cap_reg_we_d, cap_is_load_q, cap_is_load_d;

    logic [31:0] m_instr_q, m_instr_d, m_pc_q, m_pc_d, m_alu_q, m_alu_d, m_lv_q, m_lv_d;
    logic [4:0]  m_rd_q, m_rd_d;
    logic [5:0]  m_alucode_q, m_alucode_d;
    logic        m_reg_we_q, m_reg_we_d, m_is_load_q, m_is_load_d, m_mis_q, m_mis_d;

    logic [2:0]  ex_f3;
    logic [1:0]  ex_off;
    logic        ex_ls, ex_mis;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_value;

    assign ex_f3  = ex_instr[14:12];
    assign ex_off = ex_alu_result[1:0];
    assign ex_ls  = ex_is_load | ex_is_store;
    // Width comes from funct3[1:0]: 00 byte, 01 half, anything else a word.
    assign ex_mis = ((ex_f3[1:0] == 2'b01) && ex_off[0]) ||
                    (ex_f3[1] && (ex_off != 2'b00));

    always_comb begin
        st_be    = 4'hF;
        st_wdata = ex_store_value;
        case (ex_f3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ex_off;
                st_wdata = {4{ex_store_value[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << ex_off;
                st_wdata = {2{ex_store_value[15:0]}};
            end
            default: begin
                st_be    = 4'hF;
                st_wdata = ex_store_value;
            end
        endcase
    end

    mem_load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .offset_i (cap_alu_q[1:0]),
        .funct3_i (cap_instr_q[14:12]),
        .value_o  (ld_value)
    );

    always_comb begin
        state_d       = state_q;
        dreq_d        = dreq_q;
        dwe_d         = dwe_q;
        daddr_d       = daddr_q;
        dwdata_d      = dwdata_q;
        dbe_d         = dbe_q;
        cap_instr_d   = cap_instr_q;
        cap_pc_d      = cap_pc_q;
        cap_alu_d     = cap_alu_q;
        cap_rd_d      = cap_rd_q;
        cap_alucode_d = cap_alucode_q;
        cap_reg_we_d  = cap_reg_we_q;
        cap_is_load_d = cap_is_load_q;
        m_instr_d     = NOP_INSTR;
        m_pc_d        = 32'h0;
        m_alu_d       = 32'h0;
        m_lv_d        = 32'h0;
        m_rd_d        = 5'h0;
        m_alucode_d   = 6'h0;
        m_reg_we_d    = 1'b0;
        m_is_load_d   = 1'b0;
        m_mis_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid && !(ex_ls && !ex_mis)) begin
                    m_instr_d   = ex_instr;
                    m_pc_d      = ex_pc;
                    m_alu_d     = ex_alu_result;
                    m_rd_d      = ex_dstreg_num;
                    m_alucode_d = ex_alucode;
                    m_reg_we_d  = ex_ls ? 1'b0 : ex_reg_we;
                    m_is_load_d = ex_ls ? 1'b0 : ex_is_load;
                    m_mis_d     = ex_ls;
                end else if (ex_valid) begin
                    cap_instr_d   = ex_instr;
                    cap_pc_d      = ex_pc;
                    cap_alu_d     = ex_alu_result;
                    cap_rd_d      = ex_dstreg_num;
                    cap_alucode_d = ex_alucode;
                    cap_reg_we_d  = ex_reg_we;
                    cap_is_load_d = ex_is_load;
                    dreq_d        = 1'b1;
                    dwe_d         = ex_is_store;
                    daddr_d       = {ex_alu_result[31:2], 2'b00};
                    dbe_d         = ex_is_store ? st_be : 4'h0;
                    dwdata_d      = ex_is_store ? st_wdata : 32'h0;
                    state_d       = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    m_instr_d   = cap_instr_q;
                    m_pc_d      = cap_pc_q;
                    m_alu_d     = cap_alu_q;
                    m_rd_d      = cap_rd_q;
                    m_alucode_d = cap_alucode_q;
                    // dwe_q still marks a store for the whole access
                    m_reg_we_d  = cap_reg_we_q & ~dwe_q;
                    m_is_load_d = cap_is_load_q;
                    m_lv_d      = cap_is_load_q ? ld_value : 32'h0;
                    dreq_d      = 1'b0;
                    dwe_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            dreq_q        <= 1'b0;
            dwe_q         <= 1'b0;
            daddr_q       <= 32'h0;
            dwdata_q      <= 32'h0;
            dbe_q         <= 4'h0;
            cap_instr_q   <= NOP_INSTR;
            cap_pc_q      <= 32'h0;
            cap_alu_q     <= 32'h0;
            cap_rd_q      <= 5'h0;
            cap_alucode_q <= 6'h0;
            cap_reg_we_q  <= 1'b0;
            cap_is_load_q <= 1'b0;
            m_instr_q     <= NOP_INSTR;
            m_pc_q        <= 32'h0;
            m_alu_q       <= 32'h0;
            m_lv_q        <= 32'h0;
            m_rd_q        <= 5'h0;
            m_alucode_q   <= 6'h0;
            m_reg_we_q    <= 1'b0;
            m_is_load_q   <= 1'b0;
            m_mis_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            dreq_q        <= dreq_d;
            dwe_q         <= dwe_d;
            daddr_q       <= daddr_d;
            dwdata_q      <= dwdata_d;
            dbe_q         <= dbe_d;
            cap_instr_q   <= cap_instr_d;
            cap_pc_q      <= cap_pc_d;
            cap_alu_q     <= cap_alu_d;
            cap_rd_q      <= cap_rd_d;
            cap_alucode_q <= cap_alucode_d;
            cap_reg_we_q  <= cap_reg_we_d;
            cap_is_load_q <= cap_is_load_d;
            m_instr_q     <= m_instr_d;
            m_pc_q        <= m_pc_d;
            m_alu_q       <= m_alu_d;
            m_lv_q        <= m_lv_d;
            m_rd_q        <= m_rd_d;
            m_alucode_q   <= m_alucode_d;
            m_reg_we_q    <= m_reg_we_d;
            m_is_load_q   <= m_is_load_d;
            m_mis_q       <= m_mis_d;
        end
    end

    assign mem_stall      = (state_q == ACCESS);
    assign dmem_req       = dreq_q;
    assign dmem_we        = dwe_q;
    assign dmem_addr      = daddr_q;
    assign dmem_wdata     = dwdata_q;
    assign dmem_be        = dbe_q;
    assign mem_instr      = m_instr_q;
    assign mem_pc         = m_pc_q;
    assign mem_dstreg_num = m_rd_q;
    assign mem_alucode    = m_alucode_q;
    assign mem_alu_result = m_alu_q;
    assign mem_reg_we     = m_reg_we_q;
    assign mem_is_load    = m_is_load_q;
    assign mem_load_value = m_lv_q;
    assign mem_misaligned = m_mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected write_back outputs are queued when
// an instruction is driven and compared when the stage presents it.
module tb_mem_access;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_instr, ex_pc, ex_alu_result, ex_store_value;
    logic [4:0]  ex_dstreg_num;
    logic [5:0]  ex_alucode;
    logic        ex_reg_we, ex_is_load, ex_is_store;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] mem_instr, mem_pc, mem_alu_result, mem_load_value;
    logic [4:0]  mem_dstreg_num;
    logic [5:0]  mem_alucode;
    logic        mem_reg_we, mem_is_load, mem_misaligned;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr, pc, alu, lv;
        logic [4:0]  rd;
        logic [5:0]  alucode;
        logic        we, ld, mis;
    } exp_t;

    exp_t sb[$];

    mem_access dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc),
        .ex_dstreg_num(ex_dstreg_num), .ex_alucode(ex_alucode),
        .ex_alu_result(ex_alu_result), .ex_store_value(ex_store_value),
        .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_instr(mem_instr), .mem_pc(mem_pc), .mem_dstreg_num(mem_dstreg_num),
        .mem_alucode(mem_alucode), .mem_alu_result(mem_alu_result),
        .mem_reg_we(mem_reg_we), .mem_is_load(mem_is_load),
        .mem_load_value(mem_load_value), .mem_misaligned(mem_misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ex_valid = 0; ex_instr = 32'h0; ex_pc = 32'h0; ex_dstreg_num = 5'h0;
        ex_alucode = 6'h0; ex_alu_result = 32'h0; ex_store_value = 32'h0;
        ex_reg_we = 0; ex_is_load = 0; ex_is_store = 0;
    endtask

    function automatic exp_t bubble();
        exp_t e;
        e.instr = NOP; e.pc = 0; e.alu = 0; e.lv = 0; e.rd = 0;
        e.alucode = 0; e.we = 0; e.ld = 0; e.mis = 0;
        return e;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s.sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".instr"}, mem_instr, e.instr);
            chk({tag, ".pc"}, mem_pc, e.pc);
            chk({tag, ".rd"}, {27'h0, mem_dstreg_num}, {27'h0, e.rd});
            chk({tag, ".alucode"}, {26'h0, mem_alucode}, {26'h0, e.alucode});
            chk({tag, ".alu"}, mem_alu_result, e.alu);
            chk({tag, ".we"}, {31'h0, mem_reg_we}, {31'h0, e.we});
            chk({tag, ".ld"}, {31'h0, mem_is_load}, {31'h0, e.ld});
            chk({tag, ".lv"}, mem_load_value, e.lv);
            chk({tag, ".mis"}, {31'h0, mem_misaligned}, {31'h0, e.mis});
        end
    endtask

    task automatic drive_ls(input logic [2:0] f3, input logic st, input logic [31:0] addr,
                            input logic [31:0] sv, input logic [31:0] pc);
        ex_valid = 1; ex_pc = pc; ex_alu_result = addr; ex_store_value = sv;
        ex_alucode = 6'h0A; ex_reg_we = 1; ex_is_load = ~st; ex_is_store = st;
        ex_dstreg_num = st ? 5'd0 : 5'd9;
        ex_instr = st ? {7'h0, 5'd2, 5'd1, f3, 5'd0, 7'h23}
                      : {12'h0, 5'd1, f3, 5'd9, 7'h03};
    endtask

    // Aligned access: check the dmem request, answer after nwait stall cycles, check result.
    task automatic do_mem(input string tag, input logic [2:0] f3, input logic st,
                          input logic [31:0] addr, input logic [31:0] sv,
                          input logic [31:0] rdata, input int nwait,
                          input logic [3:0] xbe, input logic [31:0] xwd,
                          input logic [31:0] xlv);
        exp_t e;
        int   sc;
        drive_ls(f3, st, addr, sv, 32'h400 + addr);
        tick();
        chk({tag, ".req"}, {31'h0, dmem_req}, 32'h1);
        chk({tag, ".we_d"}, {31'h0, dmem_we}, {31'h0, st});
        chk({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({tag, ".be"}, {28'h0, dmem_be}, {28'h0, xbe});
        chk({tag, ".wdata"}, dmem_wdata, xwd);
        chk({tag, ".bub_instr"}, mem_instr, NOP);
        e.instr = ex_instr; e.pc = ex_pc; e.alu = addr; e.rd = ex_dstreg_num;
        e.alucode = 6'h0A; e.we = ~st; e.ld = ~st; e.lv = st ? 32'h0 : xlv; e.mis = 0;
        sb.push_back(e);
        sc = 0;
        for (int i = 0; i < nwait; i++) begin
            if (mem_stall) sc++;
            chk({tag, ".stall_we"}, {31'h0, mem_reg_we}, 32'h0);
            if (i == nwait - 1) begin
                dmem_ack = 1; dmem_rdata = rdata;
            end
            tick();
        end
        dmem_ack = 0; dmem_rdata = 32'h0;
        drive_idle();
        chk({tag, ".stall_cycles"}, sc, nwait);
        chk({tag, ".stall_end"}, {31'h0, mem_stall}, 32'h0);
        chk({tag, ".req_end"}, {31'h0, dmem_req}, 32'h0);
        pop_check(tag);
    endtask

    task automatic do_mis(input string tag, input logic [2:0] f3, input logic st,
                          input logic [31:0] addr);
        exp_t e;
        drive_ls(f3, st, addr, 32'h5555_AAAA, 32'h800);
        e = bubble();
        e.instr = ex_instr; e.pc = 32'h800; e.alu = addr; e.rd = ex_dstreg_num;
        e.alucode = 6'h0A; e.mis = 1;
        sb.push_back(e);
        tick();
        drive_idle();
        chk({tag, ".req"}, {31'h0, dmem_req}, 32'h0);
        chk({tag, ".stall"}, {31'h0, mem_stall}, 32'h0);
        pop_check(tag);
        sb.push_back(bubble());
        tick();
        pop_check({tag, ".after"});
    endtask

    initial begin
        exp_t e;
        rst = 0; dmem_ack = 0; dmem_rdata = 32'h0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.instr", mem_instr, NOP);
        chk("rst.req", {31'h0, dmem_req}, 32'h0);
        chk("rst.we", {31'h0, dmem_we}, 32'h0);
        chk("rst.addr", dmem_addr, 32'h0);
        chk("rst.wdata", dmem_wdata, 32'h0);
        chk("rst.be", {28'h0, dmem_be}, 32'h0);
        chk("rst.stall", {31'h0, mem_stall}, 32'h0);
        chk("rst.reg_we", {31'h0, mem_reg_we}, 32'h0);
        chk("rst.mis", {31'h0, mem_misaligned}, 32'h0);
        chk("rst.lv", mem_load_value, 32'h0);
        rst = 1;

        // ALU op passes through in one cycle
        ex_valid = 1; ex_instr = 32'h0062_82B3; ex_pc = 32'h100; ex_dstreg_num = 5'd5;
        ex_alucode = 6'h01; ex_alu_result = 32'h1234; ex_reg_we = 1;
        e = bubble();
        e.instr = 32'h0062_82B3; e.pc = 32'h100; e.rd = 5'd5; e.alucode = 6'h01;
        e.alu = 32'h1234; e.we = 1;
        sb.push_back(e);
        chk("add.stall_pre", {31'h0, mem_stall}, 32'h0);
        tick();
        drive_idle();
        chk("add.stall_post", {31'h0, mem_stall}, 32'h0);
        pop_check("add");
        sb.push_back(bubble());
        tick();
        pop_check("bubble");

        do_mem("lb",  3'b000, 0, 32'h203, 32'h0, 32'h80FF_FF12, 3, 4'h0, 32'h0, 32'hFFFF_FF80);
        do_mem("lhu", 3'b101, 0, 32'h202, 32'h0, 32'hBEEF_0000, 1, 4'h0, 32'h0, 32'h0000_BEEF);
        do_mem("sb",  3'b000, 1, 32'h101, 32'h0000_00AB, 32'h0, 2, 4'b0010, 32'hABAB_ABAB, 32'h0);
        do_mem("lh",  3'b001, 0, 32'h200, 32'h0, 32'h1234_8001, 1, 4'h0, 32'h0, 32'hFFFF_8001);
        do_mem("lb1", 3'b000, 0, 32'h201, 32'h0, 32'h0000_F700, 2, 4'h0, 32'h0, 32'hFFFF_FFF7);
        do_mem("lbu", 3'b100, 0, 32'h201, 32'h0, 32'h0000_F700, 1, 4'h0, 32'h0, 32'h0000_00F7);
        do_mem("lw",  3'b010, 0, 32'h204, 32'h0, 32'hDEAD_BEEF, 4, 4'h0, 32'h0, 32'hDEAD_BEEF);
        do_mem("lx",  3'b111, 0, 32'h208, 32'h0, 32'h0BAD_F00D, 1, 4'h0, 32'h0, 32'h0BAD_F00D);
        do_mem("sh",  3'b001, 1, 32'h102, 32'h1234_5678, 32'h0, 1, 4'b1100, 32'h5678_5678, 32'h0);
        do_mem("sw",  3'b010, 1, 32'h108, 32'hCAFE_F00D, 32'h0, 2, 4'hF, 32'hCAFE_F00D, 32'h0);

        do_mis("mis_lw", 3'b010, 0, 32'h102);
        do_mis("mis_lh", 3'b001, 0, 32'h201);
        do_mis("mis_sh", 3'b001, 1, 32'h203);

        // Ack while idle must be ignored
        dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
        sb.push_back(bubble());
        tick();
        dmem_ack = 0; dmem_rdata = 32'h0;
        chk("idle_ack.stall", {31'h0, mem_stall}, 32'h0);
        pop_check("idle_ack");

        // Reset in the middle of an access
        drive_ls(3'b010, 0, 32'h300, 32'h0, 32'h900);
        tick();
        drive_idle();
        chk("rstacc.req_pre", {31'h0, dmem_req}, 32'h1);
        rst = 0;
        #1;
        chk("rstacc.req", {31'h0, dmem_req}, 32'h0);
        chk("rstacc.stall", {31'h0, mem_stall}, 32'h0);
        repeat (2) tick();
        #3;
        rst = 1;
        tick();
        dmem_ack = 1; dmem_rdata = 32'h1357_9BDF;
        sb.push_back(bubble());
        tick();
        dmem_ack = 0; dmem_rdata = 32'h0;
        chk("rstacc.req_after", {31'h0, dmem_req}, 32'h0);
        chk("rstacc.stall_after", {31'h0, mem_stall}, 32'h0);
        pop_check("rstacc.stray_ack");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
